// File: rtl/data_bus_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package data_bus_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    typedef enum logic [1:0] {TGT_DMEM, TGT_TBMAN, TGT_NONE} target_e;

    localparam logic [3:0]  DMEM_REGION = 4'h1;
    localparam logic [19:0] TBMAN_PAGE  = 20'h8000F;

    localparam logic MASTER_M0 = 1'b0;
    localparam logic MASTER_M1 = 1'b1;

endpackage

// File: rtl/bus_region_decode.sv
// Address-to-target decode for the data bus.
// Dmem takes precedence over the tbman page.
module bus_region_decode
    import data_bus_pkg::*;
(
    input  logic [31:0] addr_i,
    output target_e     target_o
);

    always_comb begin
        target_o = TGT_NONE;
        if (addr_i[31:28] == DMEM_REGION) begin
            target_o = TGT_DMEM;
        end else if (addr_i[31:12] == TBMAN_PAGE) begin
            target_o = TGT_TBMAN;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter with per-target wait states and unmapped-address errors.
// Define ARB_FIXED_PRIO_EN to make M0 win every tie instead of round-robin.
module data_bus_arbiter
    import data_bus_pkg::*;
#(
    parameter int unsigned DMEM_WAIT  = 0,
    parameter int unsigned TBMAN_WAIT = 2,
    parameter int unsigned WAIT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_be,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_be,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_we,
    output logic        cs_dmem_n,
    output logic        cs_tbman_n,
    input  logic [31:0] dmem_rdata,
    input  logic [31:0] tbman_rdata
);

    if (DMEM_WAIT >= (2 ** WAIT_W)) begin : g_bad_dmem_wait
        $error("DMEM_WAIT does not fit in a WAIT_W-bit counter");
    end
    if (TBMAN_WAIT >= (2 ** WAIT_W)) begin : g_bad_tbman_wait
        $error("TBMAN_WAIT does not fit in a WAIT_W-bit counter");
    end

    localparam logic [WAIT_W-1:0] DMEM_CNT  = WAIT_W'(DMEM_WAIT);
    localparam logic [WAIT_W-1:0] TBMAN_CNT = WAIT_W'(TBMAN_WAIT);

    state_e            state_q;
    logic              last_grant_q;
    logic              owner_q;
    target_e           tgt_q;
    logic [WAIT_W-1:0] cnt_q;
    logic              we_q;
    logic [31:0]       bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic [3:0]        bus_be_q;
    logic              bus_we_q;
    logic              cs_dmem_n_q;
    logic              cs_tbman_n_q;
    logic              m0_ack_q;
    logic              m0_err_q;
    logic [31:0]       m0_rdata_q;
    logic              m1_ack_q;
    logic              m1_err_q;
    logic [31:0]       m1_rdata_q;

    logic              any_req;
    logic              win_m1;
    logic              win_we;
    logic [31:0]       win_addr;
    logic [31:0]       win_wdata;
    logic [3:0]        win_be;
    target_e           win_tgt;
    logic [WAIT_W-1:0] win_cnt;
    logic [31:0]       cap_rdata;

    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
            win_m1 = MASTER_M0;
`else
            win_m1 = ~last_grant_q;
`endif
        end else begin
            win_m1 = m1_req;
        end
        win_we    = win_m1 ? m1_we    : m0_we;
        win_addr  = win_m1 ? m1_addr  : m0_addr;
        win_wdata = win_m1 ? m1_wdata : m0_wdata;
        win_be    = win_m1 ? m1_be    : m0_be;
    end

    bus_region_decode u_decode (
        .addr_i   (win_addr),
        .target_o (win_tgt)
    );

    assign win_cnt   = (win_tgt == TGT_TBMAN) ? TBMAN_CNT : DMEM_CNT;
    assign cap_rdata = (tgt_q == TGT_TBMAN) ? tbman_rdata : dmem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= MASTER_M1;
            owner_q      <= MASTER_M0;
            tgt_q        <= TGT_NONE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
            bus_we_q     <= 1'b0;
            cs_dmem_n_q  <= 1'b1;
            cs_tbman_n_q <= 1'b1;
            m0_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_ack_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m1_rdata_q   <= '0;
        end else begin
            m0_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_ack_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m1_rdata_q <= '0;
            bus_we_q   <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q     <= win_m1;
                        tgt_q       <= win_tgt;
                        cnt_q       <= win_cnt;
                        we_q        <= win_we;
                        bus_addr_q  <= win_addr;
                        bus_wdata_q <= win_wdata;
                        bus_be_q    <= win_be;
                        if (win_tgt == TGT_NONE) begin
                            state_q  <= RESP;
                            m0_ack_q <= ~win_m1;
                            m0_err_q <= ~win_m1;
                            m1_ack_q <= win_m1;
                            m1_err_q <= win_m1;
                        end else begin
                            state_q      <= ACCESS;
                            cs_dmem_n_q  <= (win_tgt != TGT_DMEM);
                            cs_tbman_n_q <= (win_tgt != TGT_TBMAN);
                            // strobe must coincide with the counter==0 cycle
                            bus_we_q     <= win_we && (win_cnt == '0);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q      <= RESP;
                        cs_dmem_n_q  <= 1'b1;
                        cs_tbman_n_q <= 1'b1;
                        m0_ack_q     <= ~owner_q;
                        m1_ack_q     <= owner_q;
                        if (owner_q) begin
                            m1_rdata_q <= cap_rdata;
                        end else begin
                            m0_rdata_q <= cap_rdata;
                        end
                    end else begin
                        cnt_q    <= cnt_q - WAIT_W'(1);
                        bus_we_q <= we_q && (cnt_q == WAIT_W'(1));
                    end
                end
                RESP: begin
                    last_grant_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_be     = bus_be_q;
    assign bus_we     = bus_we_q;
    assign cs_dmem_n  = cs_dmem_n_q;
    assign cs_tbman_n = cs_tbman_n_q;
    assign m0_ack     = m0_ack_q;
    assign m0_err     = m0_err_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_ack     = m1_ack_q;
    assign m1_err     = m1_err_q;
    assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: directed scenarios plus random two-master traffic.
module tb_data_bus_arbiter;

    localparam int unsigned DW = 0;
    localparam int unsigned TW = 2;
    localparam int unsigned WW = 4;
    localparam int MAXW = (DW > TW) ? DW : TW;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_we, cs_dmem_n, cs_tbman_n;
    logic [31:0] dmem_rdata, tbman_rdata;
    logic        fix_dead;

    data_bus_arbiter #(
        .DMEM_WAIT  (DW),
        .TBMAN_WAIT (TW),
        .WAIT_W     (WW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m0_req      (m0_req),
        .m0_we       (m0_we),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_be       (m0_be),
        .m0_ack      (m0_ack),
        .m0_err      (m0_err),
        .m0_rdata    (m0_rdata),
        .m1_req      (m1_req),
        .m1_we       (m1_we),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_be       (m1_be),
        .m1_ack      (m1_ack),
        .m1_err      (m1_err),
        .m1_rdata    (m1_rdata),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_we      (bus_we),
        .cs_dmem_n   (cs_dmem_n),
        .cs_tbman_n  (cs_tbman_n),
        .dmem_rdata  (dmem_rdata),
        .tbman_rdata (tbman_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // target models: read data is a fixed function of the presented address
    assign dmem_rdata  = fix_dead ? 32'hDEAD_BEEF : {bus_addr[15:0], ~bus_addr[15:0]};
    assign tbman_rdata = bus_addr ^ 32'h1357_9BDF;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // 0 = dmem, 1 = tbman, 2 = unmapped
    function automatic int tgt_of(input logic [31:0] a);
        if ((a >> 28) == 32'd1) return 0;
        if (a >= 32'h8000_F000 && a <= 32'h8000_FFFF) return 1;
        return 2;
    endfunction

    function automatic int lat_of(input logic [31:0] a);
        case (tgt_of(a))
            0:       return 2 + int'(DW);
            1:       return 2 + int'(TW);
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] target_data(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        if (tgt_of(a) == 0) return fix_dead ? 32'hDEAD_BEEF : {lo, ~lo};
        return a ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          stamp;
        int          lat;
        int          maxlat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   ack_cnt[2];
    int   ack_log[$];

    task automatic drive(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int lat, input int maxlat);
        exp_t e;
        logic got;
        got = 1'b0;
        e.we = we; e.addr = addr; e.wdata = wdata; e.be = be;
        e.rdata = target_data(addr); e.stamp = cyc; e.lat = lat; e.maxlat = maxlat;
        if (m == 0) begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be; m0_req = 1'b1;
            q0.push_back(e);
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be; m1_req = 1'b1;
            q1.push_back(e);
        end
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack : m1_ack;
        end
        check($sformatf("ack_wait_m%0d", m), {63'd0, got}, 64'd1);
        if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    // monitor: response scoreboard plus chip-select / strobe protocol
    initial begin
        int          run_tgt, run_len, we_cnt, t;
        logic        we_last, strobe_seen, ack, err, mapped;
        logic [31:0] strobe_addr, strobe_wdata, rd;
        logic [3:0]  strobe_be;
        exp_t        e;
        run_tgt = 0; run_len = 0; we_cnt = 0; we_last = 1'b0; strobe_seen = 1'b0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run_len = 0;
                strobe_seen = 1'b0;
            end else begin
                for (int m = 0; m < 2; m++) begin
                    ack = (m == 0) ? m0_ack : m1_ack;
                    err = (m == 0) ? m0_err : m1_err;
                    rd  = (m == 0) ? m0_rdata : m1_rdata;
                    if (!ack) begin
                        check($sformatf("quiet_m%0d", m), {31'd0, err, rd}, 64'd0);
                    end else if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
                        check($sformatf("unexpected_ack_m%0d", m), 64'd1, 64'd0);
                    end else begin
                        e = (m == 0) ? q0.pop_front() : q1.pop_front();
                        ack_cnt[m]++;
                        ack_log.push_back(m);
                        mapped = (tgt_of(e.addr) != 2);
                        check($sformatf("err_m%0d", m), {63'd0, err}, {63'd0, !mapped});
                        if (mapped && !e.we)
                            check($sformatf("rdata_m%0d", m), rd, e.rdata);
                        check($sformatf("strobe_m%0d", m), {63'd0, strobe_seen}, {63'd0, e.we && mapped});
                        if (e.we && mapped && strobe_seen) begin
                            check($sformatf("strobe_addr_m%0d", m), strobe_addr, e.addr);
                            check($sformatf("strobe_data_m%0d", m), {strobe_be, strobe_wdata}, {e.be, e.wdata});
                        end
                        strobe_seen = 1'b0;
                        if (e.lat >= 0)
                            check($sformatf("latency_m%0d", m), cyc - e.stamp, e.lat);
                        if (e.maxlat >= 0)
                            check($sformatf("lat_bound_m%0d", m), {63'd0, (cyc - e.stamp) <= e.maxlat}, 64'd1);
                    end
                end
                if (!cs_dmem_n || !cs_tbman_n) begin
                    t = !cs_dmem_n ? 0 : 1;
                    check("cs_exclusive", {63'd0, cs_dmem_n | cs_tbman_n}, 64'd1);
                    check("cs_addr", tgt_of(bus_addr), t);
                    if (run_len == 0 || t != run_tgt) begin
                        run_tgt = t; run_len = 0; we_cnt = 0;
                    end
                    run_len++;
                    we_last = bus_we;
                    if (bus_we) begin
                        we_cnt++;
                        strobe_seen = 1'b1;
                        strobe_addr = bus_addr; strobe_wdata = bus_wdata; strobe_be = bus_be;
                    end
                end else begin
                    check("we_without_cs", {63'd0, bus_we}, 64'd0);
                    if (run_len != 0) begin
                        check($sformatf("cs_len_t%0d", run_tgt), run_len,
                              (run_tgt == 0) ? int'(DW) + 1 : int'(TW) + 1);
                        check("we_last_only", {63'd0, (we_cnt == 0) || (we_cnt == 1 && we_last)}, 64'd1);
                        run_len = 0;
                    end
                end
            end
        end
    end

    task automatic random_master(input int m, input int n);
        logic [31:0] a;
        int          sel, maxlat;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sel = $urandom_range(0, 9);
            if (sel < 5)       a = {4'h1, 28'($urandom)};
            else if (sel < 8)  a = {20'h8000F, 12'($urandom)};
            else if (sel == 8) a = {20'h8000E, 12'($urandom)};
            else               a = {4'($urandom_range(2, 7)), 28'($urandom)};
            maxlat = lat_of(a) + 4 + MAXW;
`ifdef ARB_FIXED_PRIO_EN
            if (m == 1) maxlat = -1;
`endif
            drive(m, 1'($urandom), a, $urandom, 4'($urandom), -1, maxlat);
        end
    endtask

    initial begin
        int exp_order[4];
        int c1;
        reset = 1'b1; fix_dead = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_dmem", {63'd0, cs_dmem_n}, 64'd1);
        check("rst_cs_tbman", {63'd0, cs_tbman_n}, 64'd1);
        check("rst_bus_we", {63'd0, bus_we}, 64'd0);
        check("rst_acks", {60'd0, m0_ack, m0_err, m1_ack, m1_err}, 64'd0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        check("rst_bus", {bus_addr, bus_wdata}, 64'd0);
        check("rst_be", {60'd0, bus_be}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // simultaneous requests, each master re-requesting right after its ack
        ack_log.delete();
        fork
            begin
                drive(0, 1'b0, 32'h1000_0100, 32'h0, 4'hF, -1, -1);
                drive(0, 1'b0, 32'h1000_0104, 32'h0, 4'hF, -1, -1);
            end
            begin
                drive(1, 1'b0, 32'h8000_F010, 32'h0, 4'hF, -1, -1);
                drive(1, 1'b0, 32'h8000_F014, 32'h0, 4'hF, -1, -1);
            end
        join
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++)
            check($sformatf("grant_order_%0d", i), (ack_log.size() > i) ? ack_log[i] : -1, exp_order[i]);

        @(negedge clk);
        fix_dead = 1'b1;
        drive(0, 1'b0, 32'h1000_0010, 32'h0, 4'hF, 2 + int'(DW), -1);
        fix_dead = 1'b0;

        @(negedge clk);
        drive(1, 1'b1, 32'h8000_F000, 32'h41, 4'hF, 2 + int'(TW), -1);

        @(negedge clk);
        drive(0, 1'b0, 32'h2000_0000, 32'h0, 4'hF, 1, -1);

        @(negedge clk);
        c1 = ack_cnt[1];
        drive(0, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 2 + int'(DW), -1);
        drive(0, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 3 + int'(DW), -1);
        check("m1_idle_during_m0", ack_cnt[1], c1);

        fork
            random_master(0, 30);
            random_master(1, 30);
        join

        // abort a tbman write mid-access
        @(negedge clk);
        c1 = ack_cnt[1];
        m1_we = 1'b1; m1_addr = 32'h8000_F004; m1_wdata = 32'hCAFE_0001; m1_be = 4'hF; m1_req = 1'b1;
        @(negedge clk);
        check("abort_cs_active", {63'd0, cs_tbman_n}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_cs_tbman", {63'd0, cs_tbman_n}, 64'd1);
        check("abort_cs_dmem", {63'd0, cs_dmem_n}, 64'd1);
        check("abort_bus_we", {63'd0, bus_we}, 64'd0);
        check("abort_ack", {62'd0, m0_ack, m1_ack}, 64'd0);
        check("abort_bus_addr", bus_addr, 64'd0);
        m1_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_ack", ack_cnt[1], c1);
        drive(0, 1'b0, 32'h1000_0040, 32'h0, 4'hF, 2 + int'(DW), -1);

        repeat (3) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
